// File: rtl/ext_mem_loader_if.sv
// Host command/response byte streams plus the IMEM and DMEM external ports
// that ext_mem_loader drives; master is the loader side.
interface ext_mem_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;

  modport master (
    input  s_valid, s_data, m_ready, rdata_ext, rdata_ext_2,
    output s_ready, m_valid, m_data, cpu_enable,
           addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );

  modport slave (
    output s_valid, s_data, m_ready, rdata_ext, rdata_ext_2,
    input  s_ready, m_valid, m_data, cpu_enable,
           addr_ext, wen_ext, ren_ext, wdata_ext,
           addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
  );
endinterface

// File: rtl/ext_mem_loader.sv
// Byte-stream command loader for the processor's IMEM/DMEM external ports;
// also owns the processor enable line (RUN/HALT).
module ext_mem_loader #(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  ext_mem_loader_if.master bus
);
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_WR, ST_RD, ST_RESP} state_t;

  localparam logic [7:0] OP_WR_IMEM = 8'h01;
  localparam logic [7:0] OP_WR_DMEM = 8'h02;
  localparam logic [7:0] OP_RD_IMEM = 8'h03;
  localparam logic [7:0] OP_RD_DMEM = 8'h04;
  localparam logic [7:0] OP_RUN     = 8'h05;
  localparam logic [7:0] OP_HALT    = 8'h06;
  localparam logic [7:0] RSP_OK     = 8'hA5;
  localparam logic [7:0] RSP_BUSY   = 8'hEB;
  localparam logic [7:0] RSP_BAD    = 8'hEE;
  localparam logic [1:0] RD_LAT_W   = 2'(RD_LAT);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_op;
  logic [2:0]  r_cnt;
  logic [15:0] r_idx;
  logic [63:0] r_wsr;
  logic [63:0] r_resp;
  logic [3:0]  r_resp_left;
  logic [1:0]  r_wait;
  logic        r_cpu_en;
  logic [63:0] r_addr_i, r_addr_d;
  logic [31:0] r_wdata_i;
  logic [63:0] r_wdata_d;
  logic        r_wen_i, r_ren_i, r_wen_d, r_ren_d;

  logic        w_s_ready, w_m_valid, w_s_hs, w_m_hs;
  logic        w_is_imem, w_is_wr, w_data_last, w_mem_op;
  logic [15:0] w_idx_nxt;
  logic [63:0] w_wsr_nxt;

  assign w_s_hs      = bus.s_valid & w_s_ready;
  assign w_m_hs      = w_m_valid & bus.m_ready;
  assign w_is_imem   = (r_op == OP_WR_IMEM) || (r_op == OP_RD_IMEM);
  assign w_is_wr     = (r_op == OP_WR_IMEM) || (r_op == OP_WR_DMEM);
  assign w_data_last = (r_cnt == (w_is_imem ? 3'd3 : 3'd7));
  assign w_mem_op    = (bus.s_data >= OP_WR_IMEM) && (bus.s_data <= OP_RD_DMEM);
  assign w_idx_nxt   = {r_idx[7:0], bus.s_data};
  // Data arrives LSB first, so bytes shift in from the top.
  assign w_wsr_nxt   = {bus.s_data, r_wsr[63:8]};

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_m_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready = 1'b1;
        if (w_s_hs) w_state_nxt = w_mem_op ? ST_ADDR : ST_RESP;
      end
      ST_ADDR: begin
        w_s_ready = 1'b1;
        if (w_s_hs && r_cnt == 3'd1) begin
          if (w_is_wr)       w_state_nxt = ST_DATA;
          else if (r_cpu_en) w_state_nxt = ST_RESP;
          else               w_state_nxt = ST_RD;
        end
      end
      ST_DATA: begin
        w_s_ready = 1'b1;
        if (w_s_hs && w_data_last) w_state_nxt = r_cpu_en ? ST_RESP : ST_WR;
      end
      ST_WR:   w_state_nxt = ST_RESP;
      ST_RD:   if (r_wait == RD_LAT_W) w_state_nxt = ST_RESP;
      ST_RESP: begin
        w_m_valid = 1'b1;
        if (w_m_hs && r_resp_left == 4'd1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_op        <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wsr       <= '0;
      r_resp      <= '0;
      r_resp_left <= '0;
      r_wait      <= '0;
      r_cpu_en    <= 1'b0;
      r_addr_i    <= '0;
      r_addr_d    <= '0;
      r_wdata_i   <= '0;
      r_wdata_d   <= '0;
      r_wen_i     <= 1'b0;
      r_ren_i     <= 1'b0;
      r_wen_d     <= 1'b0;
      r_ren_d     <= 1'b0;
    end else begin
      r_wen_i <= 1'b0;
      r_ren_i <= 1'b0;
      r_wen_d <= 1'b0;
      r_ren_d <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_s_hs) begin
          r_op  <= bus.s_data;
          r_cnt <= '0;
          r_resp_left <= 4'd1;
          case (bus.s_data)
            OP_RUN:  begin r_cpu_en <= 1'b1; r_resp <= {56'd0, RSP_OK}; end
            OP_HALT: begin r_cpu_en <= 1'b0; r_resp <= {56'd0, RSP_OK}; end
            OP_WR_IMEM, OP_WR_DMEM, OP_RD_IMEM, OP_RD_DMEM: ;
            default: r_resp <= {56'd0, RSP_BAD};
          endcase
        end
        ST_ADDR: if (w_s_hs) begin
          r_idx <= w_idx_nxt;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd1) begin
            r_cnt <= '0;
            if (!w_is_wr) begin
              if (r_cpu_en) begin
                r_resp      <= {56'd0, RSP_BUSY};
                r_resp_left <= 4'd1;
              end else begin
                r_wait <= '0;
                if (w_is_imem) begin
                  r_ren_i  <= 1'b1;
                  r_addr_i <= {46'd0, w_idx_nxt, 2'b00};
                end else begin
                  r_ren_d  <= 1'b1;
                  r_addr_d <= {45'd0, w_idx_nxt, 3'b000};
                end
              end
            end
          end
        end
        ST_DATA: if (w_s_hs) begin
          r_wsr <= w_wsr_nxt;
          r_cnt <= r_cnt + 3'd1;
          if (w_data_last) begin
            if (r_cpu_en) begin
              r_resp      <= {56'd0, RSP_BUSY};
              r_resp_left <= 4'd1;
            end else if (w_is_imem) begin
              r_wen_i   <= 1'b1;
              r_addr_i  <= {46'd0, r_idx, 2'b00};
              r_wdata_i <= w_wsr_nxt[63:32];
            end else begin
              r_wen_d   <= 1'b1;
              r_addr_d  <= {45'd0, r_idx, 3'b000};
              r_wdata_d <= w_wsr_nxt;
            end
          end
        end
        ST_WR: begin
          r_resp      <= {56'd0, RSP_OK};
          r_resp_left <= 4'd1;
        end
        ST_RD: begin
          r_wait <= r_wait + 2'd1;
          if (r_wait == RD_LAT_W) begin
            r_resp      <= w_is_imem ? {32'd0, bus.rdata_ext} : bus.rdata_ext_2;
            r_resp_left <= w_is_imem ? 4'd4 : 4'd8;
          end
        end
        ST_RESP: if (w_m_hs) begin
          r_resp      <= {8'd0, r_resp[63:8]};
          r_resp_left <= r_resp_left - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready     = w_s_ready;
  assign bus.m_valid     = w_m_valid;
  assign bus.m_data      = r_resp[7:0];
  assign bus.cpu_enable  = r_cpu_en;
  assign bus.addr_ext    = r_addr_i;
  assign bus.wen_ext     = r_wen_i;
  assign bus.ren_ext     = r_ren_i;
  assign bus.wdata_ext   = r_wdata_i;
  assign bus.addr_ext_2  = r_addr_d;
  assign bus.wen_ext_2   = r_wen_d;
  assign bus.ren_ext_2   = r_ren_d;
  assign bus.wdata_ext_2 = r_wdata_d;
endmodule

// File: tb/tb_ext_mem_loader.sv
// Randomized self-checking bench for ext_mem_loader: command-level reference
// model, IMEM/DMEM device models and a port monitor with latency checks.
module tb_ext_mem_loader;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  ext_mem_loader_if u_if ();
  ext_mem_loader #(.RD_LAT(RD_LAT)) u_dut (.clk(clk), .arst_n(arst_n), .bus(u_if));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int exp_lat = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Contents of never-written locations, known to device and model alike.
  function automatic logic [31:0] init_i(input logic [15:0] idx);
    return {idx ^ 16'h5A3C, ~idx};
  endfunction
  function automatic logic [63:0] init_d(input logic [15:0] idx);
    return {16'(idx * 3), idx ^ 16'hC3A5, ~idx, idx + 16'h1234};
  endfunction

  // Memory devices on the external ports.
  logic [31:0] mem_i [0:65535];
  logic [63:0] mem_d [0:65535];
  bit          wr_i  [0:65535];
  bit          wr_d  [0:65535];
  logic [31:0] pipe_i [RD_LAT];
  logic [63:0] pipe_d [RD_LAT];
  logic [15:0] dev_ai, dev_ad;
  assign dev_ai = u_if.addr_ext[17:2];
  assign dev_ad = u_if.addr_ext_2[18:3];

  always @(posedge clk) begin
    if (u_if.wen_ext)   begin mem_i[dev_ai] <= u_if.wdata_ext;   wr_i[dev_ai] <= 1'b1; end
    if (u_if.wen_ext_2) begin mem_d[dev_ad] <= u_if.wdata_ext_2; wr_d[dev_ad] <= 1'b1; end
    pipe_i[0] <= u_if.ren_ext   ? (wr_i[dev_ai] ? mem_i[dev_ai] : init_i(dev_ai)) : 32'hDEADBEEF;
    pipe_d[0] <= u_if.ren_ext_2 ? (wr_d[dev_ad] ? mem_d[dev_ad] : init_d(dev_ad)) : 64'hDEADBEEF_DEADBEEF;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_i[i] <= pipe_i[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign u_if.rdata_ext   = pipe_i[RD_LAT-1];
  assign u_if.rdata_ext_2 = pipe_d[RD_LAT-1];

  // Reference model state and expected port events.
  typedef struct { logic [63:0] addr; logic [63:0] data; } wr_t;
  wr_t         exp_wr_i[$], exp_wr_d[$];
  logic [63:0] exp_rd_i[$], exp_rd_d[$];
  logic [31:0] ref_i[int];
  logic [63:0] ref_d[int];
  bit          ref_cpu = 1'b0;

  logic prev_mv = 1'b0;
  always @(negedge clk) begin
    prev_mv <= u_if.m_valid;
    if (u_if.s_ready && u_if.m_valid) check("ready_valid_overlap", 1, 0);
    if (u_if.wen_ext) begin
      check("wen_i_lat", cyc - acc_cyc, 1);
      if (exp_wr_i.size() == 0) check("wen_i_unexpected", 1, 0);
      else begin
        check("wen_i_addr", u_if.addr_ext, exp_wr_i[0].addr);
        check("wen_i_data", {32'd0, u_if.wdata_ext}, exp_wr_i[0].data);
        void'(exp_wr_i.pop_front());
      end
    end
    if (u_if.wen_ext_2) begin
      check("wen_d_lat", cyc - acc_cyc, 1);
      if (exp_wr_d.size() == 0) check("wen_d_unexpected", 1, 0);
      else begin
        check("wen_d_addr", u_if.addr_ext_2, exp_wr_d[0].addr);
        check("wen_d_data", u_if.wdata_ext_2, exp_wr_d[0].data);
        void'(exp_wr_d.pop_front());
      end
    end
    if (u_if.ren_ext) begin
      check("ren_i_lat", cyc - acc_cyc, 1);
      if (exp_rd_i.size() == 0) check("ren_i_unexpected", 1, 0);
      else begin check("ren_i_addr", u_if.addr_ext, exp_rd_i[0]); void'(exp_rd_i.pop_front()); end
    end
    if (u_if.ren_ext_2) begin
      check("ren_d_lat", cyc - acc_cyc, 1);
      if (exp_rd_d.size() == 0) check("ren_d_unexpected", 1, 0);
      else begin check("ren_d_addr", u_if.addr_ext_2, exp_rd_d[0]); void'(exp_rd_d.pop_front()); end
    end
    if (u_if.m_valid && !prev_mv) check("resp_lat", cyc - acc_cyc, exp_lat);
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    u_if.s_valid = 1'b1;
    u_if.s_data  = b;
    while (!u_if.s_ready) begin
      @(negedge clk);
      t++;
      if (t > 200) begin check("cmd_timeout", 0, 1); u_if.s_valid = 1'b0; return; end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    u_if.s_valid = 1'b0;
    u_if.s_data  = 8'($urandom);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input int stall);
    int t = 0;
    bit have = 1'b0;
    logic [7:0] h = '0;
    forever begin
      @(negedge clk);
      if (have) check("resp_hold", {u_if.m_valid, u_if.m_data}, {1'b1, h});
      have = 1'b0;
      if (stall > 0 && u_if.m_valid) begin u_if.m_ready = 1'b0; stall--; end
      else u_if.m_ready = ($urandom_range(0, 3) != 0);
      if (u_if.m_valid && u_if.m_ready) break;
      if (u_if.m_valid) begin have = 1'b1; h = u_if.m_data; end
      t++;
      if (t > 200) begin check("resp_timeout", 0, 1); return; end
    end
    check("resp_byte", u_if.m_data, exp);
    @(posedge clk);
  endtask

  // One full command: build bytes, predict effects, drive, collect, compare.
  task automatic run_cmd(input logic [7:0] op, input logic [15:0] idx,
                         input logic [63:0] data, input int stall);
    logic [7:0]  bytes[$];
    logic [7:0]  resp[$];
    logic [63:0] w;
    bytes.push_back(op);
    if (op >= 8'h01 && op <= 8'h04) begin
      bytes.push_back(idx[15:8]);
      bytes.push_back(idx[7:0]);
    end
    if (op == 8'h01) for (int i = 0; i < 4; i++) bytes.push_back(data[8*i +: 8]);
    if (op == 8'h02) for (int i = 0; i < 8; i++) bytes.push_back(data[8*i +: 8]);
    exp_lat = 1;
    case (op)
      8'h01, 8'h02, 8'h03, 8'h04: begin
        if (ref_cpu) resp.push_back(8'hEB);
        else if (op == 8'h01) begin
          exp_wr_i.push_back(wr_t'{64'(idx) * 4, {32'd0, data[31:0]}});
          ref_i[int'(idx)] = data[31:0];
          resp.push_back(8'hA5);
          exp_lat = 2;
        end else if (op == 8'h02) begin
          exp_wr_d.push_back(wr_t'{64'(idx) * 8, data});
          ref_d[int'(idx)] = data;
          resp.push_back(8'hA5);
          exp_lat = 2;
        end else if (op == 8'h03) begin
          exp_rd_i.push_back(64'(idx) * 4);
          w = {32'd0, ref_i.exists(int'(idx)) ? ref_i[int'(idx)] : init_i(idx)};
          for (int i = 0; i < 4; i++) resp.push_back(w[8*i +: 8]);
          exp_lat = RD_LAT + 2;
        end else begin
          exp_rd_d.push_back(64'(idx) * 8);
          w = ref_d.exists(int'(idx)) ? ref_d[int'(idx)] : init_d(idx);
          for (int i = 0; i < 8; i++) resp.push_back(w[8*i +: 8]);
          exp_lat = RD_LAT + 2;
        end
      end
      8'h05: begin ref_cpu = 1'b1; resp.push_back(8'hA5); end
      8'h06: begin ref_cpu = 1'b0; resp.push_back(8'hA5); end
      default: resp.push_back(8'hEE);
    endcase
    foreach (bytes[i]) send_byte(bytes[i]);
    foreach (resp[i]) recv_byte(resp[i], (i == 2) ? stall : 0);
    @(negedge clk);
    check("cpu_enable", u_if.cpu_enable, ref_cpu);
    check("pending_port_events",
          exp_wr_i.size() + exp_wr_d.size() + exp_rd_i.size() + exp_rd_d.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_m_valid", u_if.m_valid, 0);
    check("rst_m_data", u_if.m_data, 0);
    check("rst_cpu_enable", u_if.cpu_enable, 0);
    check("rst_wen_ren", {u_if.wen_ext, u_if.ren_ext, u_if.wen_ext_2, u_if.ren_ext_2}, 0);
    check("rst_addr_i", u_if.addr_ext, 0);
    check("rst_wdata_i", u_if.wdata_ext, 0);
    check("rst_addr_d", u_if.addr_ext_2, 0);
    check("rst_wdata_d", u_if.wdata_ext_2, 0);
  endtask

  initial begin
    logic [7:0]  op;
    logic [15:0] idx;
    int          r;
    u_if.s_valid = 1'b0;
    u_if.s_data  = '0;
    u_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    arst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", u_if.s_ready, 1);

    run_cmd(8'h01, 16'h0003, 64'h0050_0093, 0);
    run_cmd(8'h03, 16'h0003, 64'h0, 0);
    run_cmd(8'h02, 16'h0102, 64'h1122_3344_5566_7788, 0);
    run_cmd(8'h04, 16'h0102, 64'h0, 5);
    run_cmd(8'h05, 16'h0, 64'h0, 0);
    run_cmd(8'h01, 16'h0004, 64'hCAFE_F00D, 0);
    run_cmd(8'h04, 16'h0102, 64'h0, 0);
    run_cmd(8'h06, 16'h0, 64'h0, 0);
    run_cmd(8'h03, 16'h0004, 64'h0, 0);
    run_cmd(8'h7F, 16'h0, 64'h0, 0);
    run_cmd(8'h00, 16'h0, 64'h0, 0);
    run_cmd(8'h02, 16'hFFFF, 64'hA5A5_0F0F_3C3C_9696, 0);
    run_cmd(8'h04, 16'hFFFF, 64'h0, 0);
    run_cmd(8'h01, 16'hFFFF, 64'h8765_4321, 0);
    run_cmd(8'h03, 16'hFFFF, 64'h0, 3);

    // Reset after 2 of 4 data bytes: no write, everything cleared.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h09);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    ref_cpu = 1'b0;
    check_reset_outputs();
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("rst2_s_ready", u_if.s_ready, 1);
    run_cmd(8'h03, 16'h0009, 64'h0, 0);
    run_cmd(8'h01, 16'h0009, 64'h1357_9BDF, 0);
    run_cmd(8'h03, 16'h0009, 64'h0, 0);

    for (int n = 0; n < 150 && n_fail <= 20; n++) begin
      r = $urandom_range(0, 19);
      if (r < 4)       op = 8'h01;
      else if (r < 8)  op = 8'h02;
      else if (r < 12) op = 8'h03;
      else if (r < 16) op = 8'h04;
      else if (r == 16) op = 8'h05;
      else if (r < 19) op = 8'h06;
      else             op = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(7, 255)) : 8'h00;
      r = $urandom_range(0, 9);
      idx = (r < 7) ? 16'($urandom_range(0, 7)) : ((r == 7) ? 16'hFFFF : 16'($urandom));
      run_cmd(op, idx, {32'($urandom), 32'($urandom)}, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
